id_regfile_sb: RTL and testbench

- RV32I integer register file for the ID stage: 32 x 32-bit, two combinational read ports, one write port driven by writeback.
- Includes a per-register pending-write scoreboard. It flags read-after-write hazards on the decode operands and stalls issue when a destination's in-flight count saturates.
- Its write-port signals (i_wrSig, i_wrReg, i_wrData) are the same nets the ID register logger taps.

---
 rtl/id_regfile_sb.sv | 105 ++++++++++
 tb/tb_id_regfile_sb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_regfile_sb.sv
// id_regfile_sb: RV32I 32 x XLEN register file with a per-register pending-write scoreboard.
// Optional write-to-read bypass is compiled in when REGFILE_BYPASS_EN is defined.
module id_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [4:0]      i_rdReg1,
  input  logic [4:0]      i_rdReg2,
  output logic [XLEN-1:0] o_rdData1,
  output logic [XLEN-1:0] o_rdData2,
  output logic            o_hazard1,
  output logic            o_hazard2,
  input  logic            i_issueValid,
  input  logic [4:0]      i_issueRd,
  output logic            o_issueStall,
  input  logic            i_wrSig,
  input  logic [4:0]      i_wrReg,
  input  logic [XLEN-1:0] i_wrData,
  output logic            o_wbUnderflow
);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]   regs      [32];
  logic [PEND_W-1:0] pend      [32];
  logic [PEND_W-1:0] pend_next [32];
  logic [31:0]       inc;
  logic [31:0]       dec;
  logic              wr_active;
  logic              issue_stall;
  logic              issue_accept;
  logic              wb_underflow_reg;

  assign wr_active    = i_wrSig & (i_wrReg != 5'd0);
  // A saturated counter can still accept an issue when a writeback frees a slot this cycle.
  assign issue_stall  = i_issueValid & (i_issueRd != 5'd0) & (pend[i_issueRd] == PEND_MAX)
                      & ~(i_wrSig & (i_wrReg == i_issueRd));
  assign issue_accept = i_issueValid & (i_issueRd != 5'd0) & ~issue_stall;
  assign o_issueStall  = issue_stall;
  assign o_wbUnderflow = wb_underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      assign inc[gi] = issue_accept & (i_issueRd == 5'(gi));
      assign dec[gi] = i_wrSig & (i_wrReg == 5'(gi)) & (pend[gi] != '0);
      assign pend_next[gi] = (inc[gi] & ~dec[gi]) ? pend[gi] + PEND_ONE :
                             (dec[gi] & ~inc[gi]) ? pend[gi] - PEND_ONE : pend[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) pend[i] <= pend_next[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_active) begin
      regs[i_wrReg] <= i_wrData;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb_underflow_reg <= 1'b0;
    end else if (wr_active & (pend[i_wrReg] == '0)) begin
      wb_underflow_reg <= 1'b1;
    end
  end

  logic [4:0]      rd_idx  [2];
  logic [XLEN-1:0] rd_data [2];
  logic [1:0]      hazard;

  assign rd_idx[0] = i_rdReg1;
  assign rd_idx[1] = i_rdReg2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic byp;
`ifdef REGFILE_BYPASS_EN
      assign byp = wr_active & (i_wrReg == rd_idx[gi]);
`else
      assign byp = 1'b0;
`endif
      assign rd_data[gi] = byp ? i_wrData :
                           (rd_idx[gi] == 5'd0) ? '0 : regs[rd_idx[gi]];
      // A bypassed writeback that retires the last pending write resolves the hazard now.
      assign hazard[gi] = (rd_idx[gi] != 5'd0) & (pend[rd_idx[gi]] != '0)
                        & ~(byp & (pend[rd_idx[gi]] == PEND_ONE));
    end
  endgenerate

  assign o_rdData1 = rd_data[0];
  assign o_rdData2 = rd_data[1];
  assign o_hazard1 = hazard[0];
  assign o_hazard2 = hazard[1];
endmodule

// File: tb/tb_id_regfile_sb.sv
// tb_id_regfile_sb: directed bench for id_regfile_sb with a per-cycle array model and literal pins.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_id_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_reg1, rd_reg2, issue_rd, wr_reg;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        hazard1, hazard2, issue_valid, issue_stall, wr_sig, wb_underflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic        m_uf;

  always #5 clk = ~clk;

  id_regfile_sb dut (
    .i_clk(clk), .i_reset(rst),
    .i_rdReg1(rd_reg1), .i_rdReg2(rd_reg2),
    .o_rdData1(rd_data1), .o_rdData2(rd_data2),
    .o_hazard1(hazard1), .o_hazard2(hazard2),
    .i_issueValid(issue_valid), .i_issueRd(issue_rd), .o_issueStall(issue_stall),
    .i_wrSig(wr_sig), .i_wrReg(wr_reg), .i_wrData(wr_data),
    .o_wbUnderflow(wb_underflow)
  );

  function automatic logic m_stall();
    return issue_valid && issue_rd != 0 && m_pend[issue_rd] == 3 && !(wr_sig && wr_reg == issue_rd);
  endfunction

  function automatic logic m_accept();
    return issue_valid && issue_rd != 0 && !m_stall();
  endfunction

  function automatic logic m_wbdec();
    return wr_sig && wr_reg != 0 && m_pend[wr_reg] != 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_sig && wr_reg != 0 && wr_reg == idx) return wr_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic m_hz(input logic [4:0] idx);
    if (idx == 0 || m_pend[idx] == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_sig && wr_reg == idx && m_pend[idx] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Model state advances on the same edges as the design, from the driven inputs only.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'h0;
        m_pend[i] <= 0;
      end
      m_uf <= 1'b0;
    end else begin
      if (wr_sig && wr_reg != 0) begin
        m_regs[wr_reg] <= wr_data;
        if (m_pend[wr_reg] == 0) m_uf <= 1'b1;
      end
      if (!(m_accept() && m_wbdec() && issue_rd == wr_reg)) begin
        if (m_accept()) m_pend[issue_rd] <= m_pend[issue_rd] + 1;
        if (m_wbdec())  m_pend[wr_reg]   <= m_pend[wr_reg] - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    chk("rd1",   rd_data1, m_rd(rd_reg1));
    chk("rd2",   rd_data2, m_rd(rd_reg2));
    chk("hz1",   {31'b0, hazard1}, {31'b0, m_hz(rd_reg1)});
    chk("hz2",   {31'b0, hazard2}, {31'b0, m_hz(rd_reg2)});
    chk("stall", {31'b0, issue_stall}, {31'b0, m_stall()});
    chk("uf",    {31'b0, wb_underflow}, {31'b0, m_uf});
    $display("cycle t=%0t rs1=%0d rs2=%0d iss=%b/%0d wr=%b/%0d/%h stall=%b hz=%b%b uf=%b",
             $time, rd_reg1, rd_reg2, issue_valid, issue_rd, wr_sig, wr_reg, wr_data,
             issue_stall, hazard1, hazard2, wb_underflow);
  endtask

  // Compare at the falling edge, then return just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_reg1 = 0; rd_reg2 = 0; issue_valid = 0; issue_rd = 0;
    wr_sig = 0; wr_reg = 0; wr_data = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wr_sig = 1; wr_reg = r; wr_data = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc(); cyc();
    chk("lit_reset_rd1", rd_data1, 32'h0);
    chk("lit_reset_uf", {31'b0, wb_underflow}, 32'h0);
    rst = 1'b0;

    // Build pend[5]=1, regs[5]=0x1234, then reset mid-run.
    issue(5); cyc();
    issue(5); cyc();
    idle(); wb(5, 32'h1234); cyc();
    idle(); rd_reg1 = 5; #1;
    chk("lit_x5_data", rd_data1, 32'h1234);
    chk("lit_x5_hz", {31'b0, hazard1}, 32'h1);
    rst = 1'b1; #1;
    chk("lit_rst_x5_data", rd_data1, 32'h0);
    chk("lit_rst_x5_hz", {31'b0, hazard1}, 32'h0);
    cyc();
    rst = 1'b0;
    wb(5, 32'h55); #1;
    chk("lit_pre_uf", {31'b0, wb_underflow}, 32'h0);
    cyc();
    idle(); #1;
    chk("lit_post_uf", {31'b0, wb_underflow}, 32'h1);

    // x0 is hardwired.
    wb(0, 32'hDEADBEEF); cyc();
    idle(); #1;
    chk("lit_x0_read", rd_data1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      issue(0); #1;
      chk("lit_x0_stall", {31'b0, issue_stall}, 32'h0);
      chk("lit_x0_hz", {31'b0, hazard1}, 32'h0);
      cyc();
    end

    // RAW on x7 resolved by writeback.
    idle(); issue(7); cyc();
    idle(); rd_reg1 = 7; #1;
    chk("lit_x7_hz", {31'b0, hazard1}, 32'h1);
    cyc();
    wb(7, 32'hCAFEF00D); #1;
`ifdef REGFILE_BYPASS_EN
    chk("lit_x7_byp_data", rd_data1, 32'hCAFEF00D);
    chk("lit_x7_byp_hz", {31'b0, hazard1}, 32'h0);
`else
    chk("lit_x7_wb_data", rd_data1, 32'h0);
    chk("lit_x7_wb_hz", {31'b0, hazard1}, 32'h1);
`endif
    cyc();
    idle(); rd_reg1 = 7; #1;
    chk("lit_x7_after_hz", {31'b0, hazard1}, 32'h0);
    chk("lit_x7_after_data", rd_data1, 32'hCAFEF00D);
    cyc();

    // Saturate x9.
    idle(); rd_reg2 = 9;
    for (int k = 0; k < 3; k++) begin
      issue(9); #1;
      chk("lit_x9_fill_stall", {31'b0, issue_stall}, 32'h0);
      cyc();
    end
    issue(9); #1;
    chk("lit_x9_sat_stall", {31'b0, issue_stall}, 32'h1);
    chk("lit_x9_hz2", {31'b0, hazard2}, 32'h1);
    cyc();
    issue(9); wb(9, 32'h99); #1;
    chk("lit_x9_wb_stall", {31'b0, issue_stall}, 32'h0);
    cyc();
    idle(); rd_reg2 = 9; issue(9); #1;
    chk("lit_x9_still_full", {31'b0, issue_stall}, 32'h1);
    cyc();
    idle(); rd_reg2 = 9;
    for (int k = 0; k < 3; k++) begin
      wb(9, 32'h99); cyc();
    end
    idle(); rd_reg2 = 9; #1;
    chk("lit_x9_drain_hz", {31'b0, hazard2}, 32'h0);
    chk("lit_x9_data", rd_data2, 32'h99);
    cyc();

    // Same-cycle issue and writeback on x12.
    idle(); issue(12); cyc();
    issue(12); wb(12, 32'h12121212); cyc();
    idle(); rd_reg1 = 12; #1;
    chk("lit_x12_hz", {31'b0, hazard1}, 32'h1);
    chk("lit_x12_data", rd_data1, 32'h12121212);
    cyc();
    wb(12, 32'h12121212); cyc();

    // Fresh reset, then underflow on x3 stays sticky.
    idle(); rst = 1'b1; #1;
    chk("lit_rst2_uf", {31'b0, wb_underflow}, 32'h0);
    cyc();
    rst = 1'b0;
    wb(3, 32'h33); rd_reg1 = 3; cyc();
    idle(); rd_reg1 = 3; #1;
    chk("lit_x3_data", rd_data1, 32'h33);
    chk("lit_x3_uf", {31'b0, wb_underflow}, 32'h1);
    chk("lit_x3_hz", {31'b0, hazard1}, 32'h0);
    cyc();
    idle(); issue(4); cyc();
    idle(); wb(4, 32'h44); rd_reg2 = 4; cyc();
    idle(); rd_reg2 = 4; #1;
    chk("lit_x4_data", rd_data2, 32'h44);
    chk("lit_uf_sticky", {31'b0, wb_underflow}, 32'h1);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
